// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage (word/halfword data RAM) plus MEM/WB pipeline register
//   clk, rst (async, active-low)      clock and reset
//   go, clear                         stage enable / squash (clear wins)
//   valid_mem, instruction_MEM,       EX/MEM slot contents
//   ctrl_msg_MEM, alu_out, B_MEM,
//   rw_mem
//   ram_addr / ram_dbg                display debug read port
//   mem_fwd                           combinational MEM-stage forwarding value
//   instruction_WB, rw_wb, WE_wb,     registered WB outputs / register-file port
//   w_wb, syscall_wb
//   retired                           count of valid instructions latched into WB
module mem_wb_stage #(
  parameter int RAM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        clear,
  input  logic        valid_mem,
  input  logic [31:0] instruction_MEM,
  input  logic [14:0] ctrl_msg_MEM,
  input  logic [31:0] alu_out,
  input  logic [31:0] B_MEM,
  input  logic [4:0]  rw_mem,
  input  logic [5:0]  ram_addr,
  output logic [31:0] mem_fwd,
  output logic [31:0] instruction_WB,
  output logic [4:0]  rw_wb,
  output logic        WE_wb,
  output logic [31:0] w_wb,
  output logic        syscall_wb,
  output logic [31:0] ram_dbg,
  output logic [31:0] retired
);
  logic [31:0]       r_ram [2**RAM_AW];
  logic              r_valid_wb;
  logic              w_load, w_we, w_sys, w_sto, w_half, w_hs, w_commit, w_adv;
  logic [RAM_AW-1:0] w_wa;
  logic [31:0]       w_rdata, w_ldata, w_wdata;
  logic              w_unused;
  assign w_load   = ctrl_msg_MEM[14];
  assign w_we     = ctrl_msg_MEM[9];
  assign w_sys    = ctrl_msg_MEM[8];
  assign w_sto    = ctrl_msg_MEM[3];
  assign w_half   = ctrl_msg_MEM[2];
  assign w_wa     = alu_out[RAM_AW+1:2];
  assign w_hs     = alu_out[1];
  assign w_rdata  = r_ram[w_wa];
  assign w_ldata  = w_half ? {16'h0, w_hs ? w_rdata[31:16] : w_rdata[15:0]} : w_rdata;
  assign mem_fwd  = w_load ? w_ldata : alu_out;
  // halfword store merges into the untouched half of the current word
  assign w_wdata  = !w_half ? B_MEM :
                    w_hs    ? {B_MEM[15:0], w_rdata[15:0]} : {w_rdata[31:16], B_MEM[15:0]};
  assign w_adv    = go & !clear;
  assign w_commit = valid_mem & w_sto & w_adv;
  assign ram_dbg  = r_ram[{{(RAM_AW-6){1'b0}}, ram_addr}];
  // rW_t / w_sel are consumed upstream; reserved bits and high address bits are don't-care
  assign w_unused = ^{ctrl_msg_MEM[13:10], ctrl_msg_MEM[7:4], ctrl_msg_MEM[1:0],
                      alu_out[31:RAM_AW+2], alu_out[0], r_valid_wb};
  // RAM is not reset; a store coinciding with active reset is suppressed via rst
  always_ff @(posedge clk)
    if (w_commit && rst) r_ram[w_wa] <= w_wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      instruction_WB <= '0;
      rw_wb          <= '0;
      WE_wb          <= 1'b0;
      w_wb           <= '0;
      syscall_wb     <= 1'b0;
      r_valid_wb     <= 1'b0;
      retired        <= '0;
    end else if (clear) begin
      instruction_WB <= '0;
      rw_wb          <= '0;
      WE_wb          <= 1'b0;
      w_wb           <= '0;
      syscall_wb     <= 1'b0;
      r_valid_wb     <= 1'b0;
    end else if (go) begin
      instruction_WB <= instruction_MEM;
      rw_wb          <= rw_mem;
      WE_wb          <= w_we & valid_mem;
      w_wb           <= mem_fwd;
      syscall_wb     <= w_sys & valid_mem;
      r_valid_wb     <= valid_mem;
      retired        <= retired + {31'h0, valid_mem};
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst, go, clear, valid_mem;
  logic [31:0] instruction_MEM, alu_out, B_MEM;
  logic [14:0] ctrl_msg_MEM;
  logic [4:0]  rw_mem;
  logic [5:0]  ram_addr;
  logic [31:0] mem_fwd, instruction_WB, w_wb, ram_dbg, retired;
  logic [4:0]  rw_wb;
  logic        WE_wb, syscall_wb;
  int total = 0;
  int bad = 0;
  localparam logic [14:0] C_LW = 15'h4200, C_SW = 15'h0008, C_SH = 15'h000C,
                          C_LH = 15'h4204, C_SYS = 15'h0100;
  mem_wb_stage #(.RAM_AW(10)) dut (
    .clk(clk), .rst(rst), .go(go), .clear(clear), .valid_mem(valid_mem),
    .instruction_MEM(instruction_MEM), .ctrl_msg_MEM(ctrl_msg_MEM), .alu_out(alu_out),
    .B_MEM(B_MEM), .rw_mem(rw_mem), .ram_addr(ram_addr), .mem_fwd(mem_fwd),
    .instruction_WB(instruction_WB), .rw_wb(rw_wb), .WE_wb(WE_wb), .w_wb(w_wb),
    .syscall_wb(syscall_wb), .ram_dbg(ram_dbg), .retired(retired)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [14:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rw, input logic [31:0] ins);
    valid_mem = v; ctrl_msg_MEM = c; alu_out = a; B_MEM = b; rw_mem = rw; instruction_MEM = ins;
    #1;
  endtask
  initial begin
    rst = 1'b0; go = 1'b1; clear = 1'b0; ram_addr = 6'd4;
    drive(0, 15'h0, 0, 0, 0, 0);
    #12;
    chk("rst_retired", retired, 0);
    chk("rst_we", {31'h0, WE_wb}, 0);
    chk("rst_w", w_wb, 0);
    rst = 1'b1;
    tick;
    // word store then load
    drive(1, C_SW, 32'h010, 32'h12345678, 5'd0, 32'hAC000010);
    tick;
    chk("sw_ram", ram_dbg, 32'h12345678);
    chk("sw_ret", retired, 1);
    chk("sw_we", {31'h0, WE_wb}, 0);
    drive(1, C_LW, 32'h010, 32'h0, 5'd3, 32'h8C030010);
    chk("lw_fwd", mem_fwd, 32'h12345678);
    tick;
    chk("lw_w", w_wb, 32'h12345678);
    chk("lw_we", {31'h0, WE_wb}, 1);
    chk("lw_rw", {27'h0, rw_wb}, 3);
    chk("lw_ins", instruction_WB, 32'h8C030010);
    // halfword store, same-cycle debug read shows old data
    drive(1, C_SH, 32'h012, 32'hAAAABEEF, 5'd0, 0);
    chk("sh_dbg_old", ram_dbg, 32'h12345678);
    tick;
    chk("sh_ram", ram_dbg, 32'hBEEF5678);
    drive(1, C_LH, 32'h012, 0, 5'd4, 0);
    chk("lh_hi", mem_fwd, 32'h0000BEEF);
    tick;
    drive(1, C_LH, 32'h010, 0, 5'd4, 0);
    chk("lh_lo", mem_fwd, 32'h00005678);
    tick;
    chk("lh_w", w_wb, 32'h00005678);
    chk("ret5", retired, 5);
    // async reset mid-cycle, with a store pending across the reset edge
    drive(1, C_SW, 32'h010, 32'hDEADBEEF, 5'd0, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_we", {31'h0, WE_wb}, 0);
    chk("arst_ret", retired, 0);
    chk("arst_w", w_wb, 0);
    chk("arst_ins", instruction_WB, 0);
    tick;
    rst = 1'b1;
    drive(0, 15'h0, 0, 0, 0, 0);
    chk("arst_ram", ram_dbg, 32'hBEEF5678);
    // stall then release
    ram_addr = 6'd8;
    drive(1, C_SW, 32'h020, 32'h0, 0, 0);
    tick;
    go = 1'b0;
    drive(1, C_SW, 32'h020, 32'h11111111, 0, 0);
    repeat (3) tick;
    chk("stall_ram", ram_dbg, 0);
    chk("stall_ret", retired, 1);
    go = 1'b1;
    tick;
    chk("go_ram", ram_dbg, 32'h11111111);
    chk("go_ret", retired, 2);
    // clear squashes
    clear = 1'b1;
    drive(1, C_SW | C_LW, 32'h020, 32'h22222222, 5'd7, 32'h1234);
    tick;
    clear = 1'b0;
    chk("clr_ram", ram_dbg, 32'h11111111);
    chk("clr_we", {31'h0, WE_wb}, 0);
    chk("clr_ret", retired, 2);
    chk("clr_ins", instruction_WB, 0);
    // bubble
    drive(0, 15'h0308, 32'h020, 32'h33333333, 5'd7, 0);
    tick;
    chk("bub_ram", ram_dbg, 32'h11111111);
    chk("bub_we", {31'h0, WE_wb}, 0);
    chk("bub_sys", {31'h0, syscall_wb}, 0);
    chk("bub_ret", retired, 2);
    drive(1, C_SYS, 0, 0, 0, 32'h0000000C);
    tick;
    chk("sys", {31'h0, syscall_wb}, 1);
    chk("sys_ret", retired, 3);
    // address wrap, non-load forwards alu_out
    ram_addr = 6'd4;
    drive(1, C_SW, 32'h00001010, 32'hCAFEF00D, 0, 0);
    chk("fwd_alu", mem_fwd, 32'h00001010);
    tick;
    chk("wrap_ram", ram_dbg, 32'hCAFEF00D);
    chk("wrap_w", w_wb, 32'h00001010);
    // load+store together: forward pre-store data
    ram_addr = 6'd8;
    drive(1, C_LW | C_SW, 32'h020, 32'h44444444, 5'd9, 0);
    chk("ls_fwd", mem_fwd, 32'h11111111);
    tick;
    chk("ls_ram", ram_dbg, 32'h44444444);
    chk("ls_w", w_wb, 32'h11111111);
    chk("ls_ret", retired, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
